// File: rtl/move_executor.sv
// Othello move executor: validates a placement against the board RAM,
// commits flipped discs ray by ray, then places the origin disc.
module move_executor (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_move,
  input  logic       player,
  input  logic       place,
  input  logic [2:0] cur_x,
  input  logic [2:0] cur_y,
  output logic [5:0] board_raddr,
  input  logic [1:0] board_rdata,
  output logic       board_we,
  output logic [5:0] board_waddr,
  output logic [1:0] board_wdata,
  output logic       ack,
  output logic       invalid,
  output logic       busy,
  output logic [4:0] flip_count
);

  localparam int unsigned CW  = 2;  // cell width
  localparam int unsigned XW  = 3;  // coordinate width
  localparam int unsigned AW  = 6;  // board address width
  localparam int unsigned PW  = 4;  // signed position width
  localparam int unsigned RW  = 3;  // per-ray run length
  localparam int unsigned TW  = 5;  // total flip count
  localparam int unsigned DW  = 3;  // direction index

  localparam logic [CW-1:0] BLACK = 2'b01;
  localparam logic [CW-1:0] WHITE = 2'b10;
  localparam logic signed [PW-1:0] P1 = 4'sd1;
  localparam logic signed [PW-1:0] Z0 = 4'sd0;
  localparam logic signed [PW-1:0] M1 = -4'sd1;

  typedef enum logic [3:0] {
    S_IDLE, S_ARMED, S_RD_ORG, S_CHK_ORG, S_DIR_INIT, S_STEP_RD,
    S_STEP_EV, S_FLIP, S_NEXT_DIR, S_FINISH, S_ACK, S_INVALID
  } state_t;

  state_t               state, state_d;
  logic [XW-1:0]        org_x, org_x_d, org_y, org_y_d;
  logic [CW-1:0]        own, own_d, opp;
  logic [DW-1:0]        dir, dir_d;
  logic signed [PW-1:0] pos_x, pos_x_d, pos_y, pos_y_d;
  logic signed [PW-1:0] dx, dy, step_x, step_y, init_x, init_y;
  logic [RW-1:0]        run, run_d;
  logic [TW-1:0]        total, total_d;
  logic [AW-1:0]        raddr_d, waddr_d;
  logic [CW-1:0]        wdata_d;
  logic [TW-1:0]        flip_count_d;
  logic                 we_d, ack_d, invalid_d, busy_d;
  logic                 init_on, step_on, pos_on, occupied;

  // Direction unit vector, clockwise from north.
  always_comb begin
    dx = Z0;
    dy = Z0;
    case (dir)
      3'd0:    begin dx = Z0; dy = M1; end
      3'd1:    begin dx = P1; dy = M1; end
      3'd2:    begin dx = P1; dy = Z0; end
      3'd3:    begin dx = P1; dy = P1; end
      3'd4:    begin dx = Z0; dy = P1; end
      3'd5:    begin dx = M1; dy = P1; end
      3'd6:    begin dx = M1; dy = Z0; end
      default: begin dx = M1; dy = M1; end
    endcase
  end

  assign opp      = {own[0], own[1]};
  assign init_x   = $signed({1'b0, org_x}) + dx;
  assign init_y   = $signed({1'b0, org_y}) + dy;
  assign step_x   = pos_x + dx;
  assign step_y   = pos_y + dy;
  // Only -1 and 8 are reachable, both of which set the sign bit.
  assign init_on  = !(init_x[PW-1] | init_y[PW-1]);
  assign step_on  = !(step_x[PW-1] | step_y[PW-1]);
  assign pos_on   = !(pos_x[PW-1] | pos_y[PW-1]);
  assign occupied = (board_rdata == BLACK) || (board_rdata == WHITE);

  // Next state plus the next value of every registered output.
  always_comb begin
    state_d      = state;
    org_x_d      = org_x;
    org_y_d      = org_y;
    own_d        = own;
    dir_d        = dir;
    pos_x_d      = pos_x;
    pos_y_d      = pos_y;
    run_d        = run;
    total_d      = total;
    raddr_d      = board_raddr;
    waddr_d      = board_waddr;
    wdata_d      = board_wdata;
    flip_count_d = flip_count;
    we_d         = 1'b0;
    ack_d        = 1'b0;
    invalid_d    = 1'b0;
    case (state)
      S_IDLE: if (new_move) state_d = S_ARMED;
      S_ARMED: begin
        if (!new_move) begin
          state_d = S_IDLE;
        end else if (place) begin
          org_x_d = cur_x;
          org_y_d = cur_y;
          own_d   = player ? WHITE : BLACK;
          raddr_d = {cur_y, cur_x};
          state_d = S_RD_ORG;
        end
      end
      S_RD_ORG: state_d = S_CHK_ORG;
      S_CHK_ORG: begin
        if (occupied) begin
          invalid_d = 1'b1;
          state_d   = S_INVALID;
        end else begin
          dir_d   = '0;
          total_d = '0;
          state_d = S_DIR_INIT;
        end
      end
      S_DIR_INIT: begin
        pos_x_d = init_x;
        pos_y_d = init_y;
        run_d   = '0;
        if (init_on) raddr_d = {init_y[XW-1:0], init_x[XW-1:0]};
        state_d = S_STEP_RD;
      end
      S_STEP_RD: state_d = pos_on ? S_STEP_EV : S_NEXT_DIR;
      S_STEP_EV: begin
        if (board_rdata == opp) begin
          run_d   = run + 3'd1;
          pos_x_d = step_x;
          pos_y_d = step_y;
          if (step_on) raddr_d = {step_y[XW-1:0], step_x[XW-1:0]};
          state_d = S_STEP_RD;
        end else if (board_rdata == own && run != '0) begin
          pos_x_d = init_x;
          pos_y_d = init_y;
          total_d = total + TW'(run);
          we_d    = 1'b1;
          waddr_d = {init_y[XW-1:0], init_x[XW-1:0]};
          wdata_d = own;
          state_d = S_FLIP;
        end else begin
          state_d = S_NEXT_DIR;
        end
      end
      // board_waddr tracks pos here; run counts down the remaining flips.
      S_FLIP: begin
        run_d   = run - 3'd1;
        pos_x_d = step_x;
        pos_y_d = step_y;
        if (run == 3'd1) begin
          state_d = S_NEXT_DIR;
        end else begin
          we_d    = 1'b1;
          waddr_d = {step_y[XW-1:0], step_x[XW-1:0]};
        end
      end
      S_NEXT_DIR: begin
        if (dir == 3'd7) begin
          state_d = S_FINISH;
          if (total != '0) begin
            we_d    = 1'b1;
            waddr_d = {org_y, org_x};
            wdata_d = own;
          end
        end else begin
          dir_d   = dir + 3'd1;
          state_d = S_DIR_INIT;
        end
      end
      S_FINISH: begin
        if (total != '0) begin
          flip_count_d = total;
          ack_d        = 1'b1;
          state_d      = S_ACK;
        end else begin
          invalid_d = 1'b1;
          state_d   = S_INVALID;
        end
      end
      S_ACK:     state_d = S_IDLE;
      S_INVALID: state_d = new_move ? S_ARMED : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    busy_d = !(state_d == S_IDLE || state_d == S_ARMED);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      org_x       <= '0;
      org_y       <= '0;
      own         <= '0;
      dir         <= '0;
      pos_x       <= '0;
      pos_y       <= '0;
      run         <= '0;
      total       <= '0;
      board_raddr <= '0;
      board_we    <= 1'b0;
      board_waddr <= '0;
      board_wdata <= '0;
      ack         <= 1'b0;
      invalid     <= 1'b0;
      busy        <= 1'b0;
      flip_count  <= '0;
    end else begin
      state       <= state_d;
      org_x       <= org_x_d;
      org_y       <= org_y_d;
      own         <= own_d;
      dir         <= dir_d;
      pos_x       <= pos_x_d;
      pos_y       <= pos_y_d;
      run         <= run_d;
      total       <= total_d;
      board_raddr <= raddr_d;
      board_we    <= we_d;
      board_waddr <= waddr_d;
      board_wdata <= wdata_d;
      ack         <= ack_d;
      invalid     <= invalid_d;
      busy        <= busy_d;
      flip_count  <= flip_count_d;
    end
  end

endmodule

// File: tb/tb_move_executor.sv
// Bench for move_executor: board RAM model plus a direct Othello rule model
// predicting writes, outcome, flip count and latency of every move.
module tb_move_executor;

  logic       clock = 1'b0;
  logic       reset;
  logic       new_move;
  logic       player;
  logic       place;
  logic [2:0] cur_x;
  logic [2:0] cur_y;
  logic [5:0] board_raddr;
  logic [1:0] board_rdata;
  logic       board_we;
  logic [5:0] board_waddr;
  logic [1:0] board_wdata;
  logic       ack;
  logic       invalid;
  logic       busy;
  logic [4:0] flip_count;

  move_executor dut (
    .clock       (clock),
    .reset       (reset),
    .new_move    (new_move),
    .player      (player),
    .place       (place),
    .cur_x       (cur_x),
    .cur_y       (cur_y),
    .board_raddr (board_raddr),
    .board_rdata (board_rdata),
    .board_we    (board_we),
    .board_waddr (board_waddr),
    .board_wdata (board_wdata),
    .ack         (ack),
    .invalid     (invalid),
    .busy        (busy),
    .flip_count  (flip_count)
  );

  always #5 clock = ~clock;

  logic [1:0] mem   [64];
  logic [1:0] ref_b [64];
  logic       load_req;

  // Synchronous-read board RAM; load_req copies the reference image in.
  always @(posedge clock) begin
    if (load_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= ref_b[i];
    end else if (board_we) begin
      mem[board_waddr] <= board_wdata;
    end
    board_rdata <= mem[board_raddr];
  end

  int n_vec = 0;
  int n_err = 0;
  int last_fc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int DX[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int DY[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  logic [7:0] exp_q[$];
  int         exp_total;
  int         exp_lat;
  bit         exp_legal;

  // Rule model: walk each ray on the reference board, collect flips in order.
  task automatic model_move(input bit pl, input int x, input int y);
    int own, opp, cx, cy, n, k, cost, s;
    bit done;
    logic [1:0] c;
    own = pl ? 2 : 1;
    opp = pl ? 1 : 2;
    exp_q.delete();
    exp_total = 0;
    c = ref_b[y*8 + x];
    if (c == 2'd1 || c == 2'd2) begin
      exp_legal = 1'b0;
      exp_lat   = 3;
      return;
    end
    s = 0;
    for (int d = 0; d < 8; d++) begin
      cx = x + DX[d];
      cy = y + DY[d];
      n = 0; k = 0; cost = 2; done = 1'b0;
      while (!done) begin
        if (cx < 0 || cx > 7 || cy < 0 || cy > 7) begin
          cost++;
          done = 1'b1;
        end else begin
          k++;
          c = ref_b[cy*8 + cx];
          if (int'(c) == opp) begin
            n++;
            cx += DX[d];
            cy += DY[d];
          end else begin
            if (int'(c) == own && n > 0) begin
              for (int i = 1; i <= n; i++)
                exp_q.push_back({6'((y + i*DY[d])*8 + x + i*DX[d]), 2'(own)});
              exp_total += n;
              cost += n;
            end
            done = 1'b1;
          end
        end
      end
      s += cost + 2*k;
    end
    exp_legal = (exp_total > 0);
    if (exp_legal) exp_q.push_back({6'(y*8 + x), 2'(own)});
    exp_lat = 4 + s;
  endtask

  task automatic load_board();
    load_req = 1'b1;
    @(posedge clock);
    #1 load_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic set_opening();
    for (int i = 0; i < 64; i++) ref_b[i] = 2'd0;
    ref_b[3*8 + 3] = 2'd2;
    ref_b[4*8 + 4] = 2'd2;
    ref_b[3*8 + 4] = 2'd1;
    ref_b[4*8 + 3] = 2'd1;
  endtask

  // Runs one move from a negedge; disturb re-pulses place and drops new_move.
  task automatic do_move(input bit pl, input int x, input int y, input bit skip_arm, input bit disturb);
    logic [7:0] got_q[$];
    int  cyc, busy_bad, nbad, nmin;
    bit  seen;
    model_move(pl, x, y);
    if (!skip_arm) begin
      new_move = 1'b1;
      @(negedge clock);
    end
    player = pl;
    cur_x  = 3'(x);
    cur_y  = 3'(y);
    place  = 1'b1;
    @(negedge clock);
    place = 1'b0;
    cyc = 1; seen = 1'b0; busy_bad = 0;
    while (!seen && cyc < 400) begin
      if (busy !== 1'b1) busy_bad++;
      if (board_we === 1'b1) got_q.push_back({board_waddr, board_wdata});
      if (ack === 1'b1 || invalid === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (disturb && cyc == 2) place = 1'b1;
        if (disturb && cyc == 3) begin
          place    = 1'b0;
          new_move = 1'b0;
        end
        @(negedge clock);
        cyc++;
      end
    end
    check("pulse_seen", 32'(seen), 32'(1));
    check("ack", 32'(ack), 32'(exp_legal));
    check("invalid", 32'(invalid), 32'(!exp_legal));
    check("latency", 32'(cyc), 32'(exp_lat));
    check("busy_during", 32'(busy_bad), 32'(0));
    if (exp_legal) last_fc = exp_total;
    check("flip_count", 32'(flip_count), 32'(last_fc));
    check("n_writes", 32'(got_q.size()), 32'(exp_q.size()));
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) check("write", 32'(got_q[i]), 32'(exp_q[i]));
    for (int i = 0; i < exp_q.size(); i++) ref_b[exp_q[i][7:2]] = exp_q[i][1:0];
    @(negedge clock);
    check("pulse_width", 32'({ack, invalid}), 32'(0));
    check("busy_after", 32'(busy), 32'(0));
    nbad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_b[i]) nbad++;
    check("board", 32'(nbad), 32'(0));
    if (disturb) begin
      // In IDLE a place coinciding with new_move must be ignored.
      new_move = 1'b1;
      place    = 1'b1;
      @(negedge clock);
      place = 1'b0;
      check("idle_after_drop", 32'(busy), 32'(0));
    end
  endtask

  task automatic reset_during_flip();
    set_opening();
    load_board();
    new_move = 1'b1;
    @(negedge clock);
    player = 1'b0;
    cur_x  = 3'd3;
    cur_y  = 3'd2;
    place  = 1'b1;
    @(negedge clock);
    place = 1'b0;
    for (int i = 0; i < 100 && board_we !== 1'b1; i++) @(negedge clock);
    check("flip_reached", 32'(board_we), 32'(1));
    #2 reset = 1'b0;
    #1;
    check("reset_outs", 32'({board_raddr, board_we, board_waddr, board_wdata,
                             ack, invalid, busy, flip_count}), 32'(0));
    @(negedge clock);
    reset = 1'b1;
    last_fc = 0;
    place = 1'b1;
    @(negedge clock);
    place = 1'b0;
    check("idle_after_reset", 32'(busy), 32'(0));
    set_opening();
    load_board();
    do_move(1'b0, 3, 2, 1'b0, 1'b0);
  endtask

  initial begin
    int r, x, y;
    bit pl;
    reset    = 1'b0;
    new_move = 1'b0;
    place    = 1'b0;
    player   = 1'b0;
    cur_x    = '0;
    cur_y    = '0;
    load_req = 1'b0;
    #12;
    check("reset_state", 32'({board_raddr, board_we, board_waddr, board_wdata,
                              ack, invalid, busy, flip_count}), 32'(0));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    set_opening();
    load_board();
    do_move(1'b0, 3, 2, 1'b0, 1'b0);

    // Occupied origin, then an immediate retry proves the return to ARMED.
    set_opening();
    load_board();
    do_move(1'b0, 3, 3, 1'b0, 1'b0);
    do_move(1'b0, 3, 2, 1'b1, 1'b0);

    set_opening();
    load_board();
    do_move(1'b0, 0, 0, 1'b0, 1'b0);

    // White at (3,4): three black discs east, two south.
    for (int i = 0; i < 64; i++) ref_b[i] = 2'd0;
    ref_b[4*8 + 4] = 2'd1;
    ref_b[4*8 + 5] = 2'd1;
    ref_b[4*8 + 6] = 2'd1;
    ref_b[4*8 + 7] = 2'd2;
    ref_b[5*8 + 3] = 2'd1;
    ref_b[6*8 + 3] = 2'd1;
    ref_b[7*8 + 3] = 2'd2;
    load_board();
    do_move(1'b1, 3, 4, 1'b0, 1'b0);

    set_opening();
    load_board();
    do_move(1'b0, 3, 2, 1'b0, 1'b1);

    reset_during_flip();

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 64; i++) begin
        r = int'($urandom_range(9));
        ref_b[i] = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      end
      x  = int'($urandom_range(7));
      y  = int'($urandom_range(7));
      pl = 1'($urandom_range(1));
      if ($urandom_range(1) == 1) ref_b[y*8 + x] = 2'd0;
      load_board();
      do_move(pl, x, y, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
